// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: run/stop/clear controller for a cascaded BCD counter chain.
// A prescaler divides clk into count ticks while running. The BCD count ripples
// its carries across the digits and flags the all-nines to all-zeros roll-over.
// On reaching a programmable BCD target the controller parks in DONE.
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  input  logic [4*DIGITS-1:0]   i_target,
  output logic [4*DIGITS-1:0]   o_q,
  output logic                  o_running,
  output logic                  o_paused,
  output logic                  o_done,
  output logic                  o_tick,
  output logic                  o_wrap
);

  localparam int QW = 4 * DIGITS;
  // Keep the prescaler at least one bit wide so PRESCALE=1 still elaborates.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [QW-1:0]   r_q, w_q_nxt, w_q_inc;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic            r_tick, w_tick_nxt;
  logic            r_wrap, w_wrap_nxt;
  logic            r_running, r_paused, r_done;

  // Increment a BCD word: a digit advances only when every lower digit is 9.
  function automatic logic [QW-1:0] bcd_inc(input logic [QW-1:0] v);
    logic [QW-1:0] res;
    logic          carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end else begin
        res[4*i +: 4] = v[4*i +: 4];
      end
    end
    return res;
  endfunction

  // Clamp every nibble of a preset into the legal 0-9 range.
  function automatic logic [QW-1:0] bcd_sat(input logic [QW-1:0] v);
    logic [QW-1:0] res;
    res = v;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return res;
  endfunction

  // True when every digit reads 9, i.e. the next increment wraps.
  function automatic logic bcd_all_nines(input logic [QW-1:0] v);
    logic res;
    res = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) begin
        res = 1'b0;
      end
    end
    return res;
  endfunction

  assign w_q_inc = bcd_inc(r_q);

  // Next-state, count and pulse logic; clear beats load beats start/stop.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
      w_q_nxt     = '0;
      w_presc_nxt = '0;
    end else if (i_load && (r_state == S_IDLE || r_state == S_PAUSE)) begin
      w_q_nxt     = bcd_sat(i_load_val);
      w_presc_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE, S_PAUSE: begin
          if (i_start) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            w_state_nxt = S_PAUSE;
          end else if (r_presc == PMAX) begin
            w_presc_nxt = '0;
            w_q_nxt     = w_q_inc;
            w_tick_nxt  = 1'b1;
            w_wrap_nxt  = bcd_all_nines(r_q);
            if (w_q_inc == i_target) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_RUN;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, count, prescaler and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_q       <= '0;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
      r_paused  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_q       <= w_q_nxt;
      r_presc   <= w_presc_nxt;
      r_tick    <= w_tick_nxt;
      r_wrap    <= w_wrap_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_paused  <= (w_state_nxt == S_PAUSE);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  assign o_q       = r_q;
  assign o_running = r_running;
  assign o_paused  = r_paused;
  assign o_done    = r_done;
  assign o_tick    = r_tick;
  assign o_wrap    = r_wrap;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: two instances (PRESCALE 4 and 1) share the same
// controls. An integer-arithmetic reference model predicts each edge; a monitor
// pops the predictions at the falling edge and compares.
module tb_bcd_stopwatch_ctrl;

  localparam logic [4:0] F_RUN  = 5'b10000;
  localparam logic [4:0] F_PAU  = 5'b01000;
  localparam logic [4:0] F_DONE = 5'b00100;
  localparam logic [4:0] F_TICK = 5'b00010;
  localparam logic [4:0] F_WRAP = 5'b00001;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset, start, stop, clear, load;
  logic [15:0] load_val, target;

  logic [15:0] q4, q1;
  logic run4, pau4, done4, tick4, wrap4;
  logic run1, pau1, done1, tick1, wrap1;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.DIGITS(4), .PRESCALE(4)) u4 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop), .i_clear(clear),
    .i_load(load), .i_load_val(load_val), .i_target(target), .o_q(q4),
    .o_running(run4), .o_paused(pau4), .o_done(done4), .o_tick(tick4), .o_wrap(wrap4));

  bcd_stopwatch_ctrl #(.DIGITS(4), .PRESCALE(1)) u1 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop), .i_clear(clear),
    .i_load(load), .i_load_val(load_val), .i_target(target), .o_q(q1),
    .o_running(run1), .o_paused(pau1), .o_done(done1), .o_tick(tick1), .o_wrap(wrap1));

  typedef struct { int k; logic [15:0] q; logic [4:0] fl; } sexp_t;
  typedef struct { int k; string nm; logic [15:0] q; logic [4:0] fl; } dexp_t;

  sexp_t sq[$];
  dexp_t dq[$];
  int n_push = 0;
  int m_st[2];
  int m_cnt[2];
  int m_ph[2];
  logic end_req = 1'b0;

  // BCD word to integer, or -1 if any nibble is not a decimal digit.
  function automatic int bcd_to_int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      if (v[4*i +: 4] > 4'd9) return -1;
      r = r * 10 + int'(v[4*i +: 4]);
    end
    return r;
  endfunction

  // Preset value with each nibble above 9 clamped to 9.
  function automatic int load_to_int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      r = r * 10 + ((v[4*i +: 4] > 4'd9) ? 9 : int'(v[4*i +: 4]));
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int d;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      d = x % 10;
      r[4*i +: 4] = d[3:0];
      x = x / 10;
    end
    return r;
  endfunction

  // Apply the current controls for one edge: predict both instances, then clock.
  task automatic step();
    sexp_t e[2];
    for (int k = 0; k < 2; k++) begin
      int p;
      logic tk, wr;
      p  = (k == 0) ? 4 : 1;
      tk = 1'b0;
      wr = 1'b0;
      if (reset || clear) begin
        m_st[k] = M_IDLE; m_cnt[k] = 0; m_ph[k] = 0;
      end else if (load && (m_st[k] == M_IDLE || m_st[k] == M_PAUSE)) begin
        m_cnt[k] = load_to_int(load_val); m_ph[k] = 0;
      end else if (m_st[k] == M_RUN && stop) begin
        m_st[k] = M_PAUSE;
      end else if ((m_st[k] == M_IDLE || m_st[k] == M_PAUSE) && start) begin
        m_st[k] = M_RUN;
      end else if (m_st[k] == M_RUN) begin
        m_ph[k] = m_ph[k] + 1;
        if (m_ph[k] == p) begin
          m_ph[k]  = 0;
          m_cnt[k] = (m_cnt[k] + 1) % 10000;
          tk = 1'b1;
          wr = (m_cnt[k] == 0);
          if (m_cnt[k] == bcd_to_int(target)) m_st[k] = M_DONE;
        end
      end
      e[k].k  = k;
      e[k].q  = to_bcd(m_cnt[k]);
      e[k].fl = {m_st[k] == M_RUN, m_st[k] == M_PAUSE, m_st[k] == M_DONE, tk, wr};
    end
    @(posedge clk);
    #1;
    sq.push_back(e[0]);
    sq.push_back(e[1]);
    n_push = n_push + 2;
  endtask

  // Queue a directed expectation checked at the coming falling edge.
  task automatic dchk(input int k, input string nm, input logic [15:0] q, input logic [4:0] fl);
    dexp_t d;
    d.k = k; d.nm = nm; d.q = q; d.fl = fl;
    dq.push_back(d);
  endtask

  // Monitor: compare every queued prediction against the live outputs, then summarise.
  int n_checks = 0, n_err = 0, n_pop = 0;
  always @(negedge clk) begin
    sexp_t se;
    dexp_t de;
    logic [15:0] aq;
    logic [4:0] af;
    while (sq.size() > 0) begin
      se = sq.pop_front();
      n_pop = n_pop + 1;
      aq = (se.k == 0) ? q4 : q1;
      af = (se.k == 0) ? {run4, pau4, done4, tick4, wrap4} : {run1, pau1, done1, tick1, wrap1};
      n_checks = n_checks + 1;
      if (aq !== se.q || af !== se.fl) begin
        n_err = n_err + 1;
        $display("FAIL model inst=%0d t=%0t actual q=%h fl=%b required q=%h fl=%b",
                 se.k, $time, aq, af, se.q, se.fl);
      end
    end
    while (dq.size() > 0) begin
      de = dq.pop_front();
      aq = (de.k == 0) ? q4 : q1;
      af = (de.k == 0) ? {run4, pau4, done4, tick4, wrap4} : {run1, pau1, done1, tick1, wrap1};
      n_checks = n_checks + 1;
      if (aq !== de.q || af !== de.fl) begin
        n_err = n_err + 1;
        $display("FAIL %s inst=%0d actual q=%h fl=%b required q=%h fl=%b",
                 de.nm, de.k, aq, af, de.q, de.fl);
      end
    end
    if (end_req) begin
      n_checks = n_checks + 1;
      if (n_pop != n_push || n_push == 0) begin
        n_err = n_err + 1;
        $display("FAIL drain actual popped=%0d required pushed=%0d", n_pop, n_push);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
    end
  end

  initial begin
    int t;
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    load_val = 16'h0000; target = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin m_st[k] = M_IDLE; m_cnt[k] = 0; m_ph[k] = 0; end

    // Reset state
    step(); reset = 1'b0;
    dchk(0, "reset4", 16'h0000, 5'b00000); dchk(1, "reset1", 16'h0000, 5'b00000);

    // T1: first tick four edges after start, then one tick every four edges
    start = 1'b1; step(); start = 1'b0; dchk(0, "t1_start", 16'h0000, F_RUN);
    repeat (3) step(); dchk(0, "t1_pre", 16'h0000, F_RUN);
    step(); dchk(0, "t1_first", 16'h0001, F_RUN | F_TICK);
    repeat (3) step(); dchk(0, "t1_gap", 16'h0001, F_RUN);
    step(); dchk(0, "t1_second", 16'h0002, F_RUN | F_TICK);

    // T2: carry ripples across two digits
    clear = 1'b1; step(); clear = 1'b0;
    load = 1'b1; load_val = 16'h0099; step(); load = 1'b0; dchk(1, "t2_load", 16'h0099, 5'b00000);
    start = 1'b1; step(); start = 1'b0; dchk(1, "t2_start", 16'h0099, F_RUN);
    step(); dchk(1, "t2_carry", 16'h0100, F_RUN | F_TICK);
    step(); dchk(1, "t2_next", 16'h0101, F_RUN | F_TICK);

    // T3: wrap through all-nines, then stop on target
    clear = 1'b1; step(); clear = 1'b0;
    load = 1'b1; load_val = 16'h9998; step(); load = 1'b0;
    target = 16'h0002;
    start = 1'b1; step(); start = 1'b0;
    step(); dchk(1, "t3_9999", 16'h9999, F_RUN | F_TICK);
    step(); dchk(1, "t3_wrap", 16'h0000, F_RUN | F_TICK | F_WRAP);
    step(); dchk(1, "t3_0001", 16'h0001, F_RUN | F_TICK);
    step(); dchk(1, "t3_done", 16'h0002, F_DONE | F_TICK);
    start = 1'b1; repeat (20) step(); start = 1'b0;
    dchk(1, "t3_hold", 16'h0002, F_DONE); dchk(0, "t3_done4", 16'h0002, F_DONE);
    target = 16'hFFFF;

    // T4: pause holds prescaler phase
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    stop = 1'b1; step(); stop = 1'b0; dchk(0, "t4_pause", 16'h0000, F_PAU);
    repeat (10) step(); dchk(0, "t4_frozen", 16'h0000, F_PAU);
    start = 1'b1; step(); start = 1'b0; dchk(0, "t4_restart", 16'h0000, F_RUN);
    step(); dchk(0, "t4_pre", 16'h0000, F_RUN);
    step(); dchk(0, "t4_inc", 16'h0001, F_RUN | F_TICK);

    // T5: clear beats load and start; saturating load
    clear = 1'b1; load = 1'b1; start = 1'b1; load_val = 16'h1234; step();
    clear = 1'b0; start = 1'b0;
    dchk(0, "t5_clear4", 16'h0000, 5'b00000); dchk(1, "t5_clear1", 16'h0000, 5'b00000);
    load_val = 16'hA5F3; step(); load = 1'b0;
    dchk(0, "t5_sat4", 16'h9593, 5'b00000); dchk(1, "t5_sat1", 16'h9593, 5'b00000);

    // T6: reset mid-RUN and in DONE
    start = 1'b1; step(); start = 1'b0; repeat (3) step();
    reset = 1'b1; step(); reset = 1'b0;
    dchk(0, "t6_rst_run4", 16'h0000, 5'b00000); dchk(1, "t6_rst_run1", 16'h0000, 5'b00000);
    target = 16'h0003;
    start = 1'b1; step(); start = 1'b0; repeat (5) step();
    dchk(1, "t6_done", 16'h0003, F_DONE);
    reset = 1'b1; step(); reset = 1'b0;
    dchk(1, "t6_rst_done", 16'h0000, 5'b00000);
    target = 16'hFFFF;

    // Randomized controls checked against the model
    repeat (3000) begin
      if ($urandom_range(0, 99) < 3) begin
        t = $urandom_range(0, 9999);
        target = to_bcd(t);
        load_val = to_bcd((t + 10000 - $urandom_range(1, 40)) % 10000);
      end else if ($urandom_range(0, 99) < 5) begin
        load_val = 16'($urandom());
      end
      reset = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 79) == 0);
      load  = ($urandom_range(0, 24) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      step();
    end
    reset = 1'b0; clear = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    end_req = 1'b1;
  end

endmodule
